// File: rtl/torus_lookahead_router_pkg.sv
// rtl/torus_lookahead_router_pkg.sv - shared NoC types and constants for the lookahead router
package noc;

  localparam int kXDim = 4;
  localparam int kYDim = 4;
  localparam int kXW   = $clog2(kXDim);
  localparam int kYW   = $clog2(kYDim);

  typedef struct packed {
    logic [kXW-1:0] x;
    logic [kYW-1:0] y;
  } xy_t;

  typedef logic [4:0] direction_t;

  localparam int kNorthPort = 0;
  localparam int kSouthPort = 1;
  localparam int kWestPort  = 2;
  localparam int kEastPort  = 3;
  localparam int kLocalPort = 4;

  localparam direction_t goNorth = 5'b00001;
  localparam direction_t goSouth = 5'b00010;
  localparam direction_t goWest  = 5'b00100;
  localparam direction_t goEast  = 5'b01000;
  localparam direction_t goLocal = 5'b10000;

  // A torus offset of exactly half the ring goes East (or South).
  localparam bit kTieEast = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } port_state_t;

  typedef struct packed {
    direction_t dir;
    logic       err;
  } route_res_t;

  function automatic logic is_onehot(input direction_t d);
    return (d != '0) && ((d & (d - 5'd1)) == '0);
  endfunction

endpackage

// File: rtl/torus_lookahead_router_port_slice.sv
// rtl/torus_lookahead_router_port_slice.sv - per-port packet FSM, held route and output register
module lookahead_port_slice
  import noc::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_head,
  input  logic       i_tail,
  input  direction_t i_route,
  input  logic       i_route_err,
  output logic       o_valid,
  input  logic       i_out_ready,
  output direction_t o_next_routing,
  output logic       o_err
);

  port_state_t r_state;
  direction_t  r_route_q;
  direction_t  r_out_route;
  logic        r_out_valid;
  logic        r_err;
  logic        w_push;

  assign o_ready        = !r_out_valid || i_out_ready;
  assign w_push         = i_valid && o_ready;
  assign o_valid        = r_out_valid;
  assign o_next_routing = r_out_route;
  assign o_err          = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_route_q   <= '0;
      r_out_route <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_push) begin
      r_out_valid <= 1'b1;
      if (i_head) begin
        // A head inside a packet is flagged but still starts a fresh packet.
        r_out_route <= i_route;
        if (i_route_err || (r_state == ST_PKT)) r_err <= 1'b1;
        if (i_tail) begin
          r_state <= ST_IDLE;
        end else begin
          r_state   <= ST_PKT;
          r_route_q <= i_route;
        end
      end else if (r_state == ST_PKT) begin
        r_out_route <= r_route_q;
        if (i_tail) r_state <= ST_IDLE;
      end else begin
        r_out_route <= '0;
        r_err       <= 1'b1;
      end
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/torus_lookahead_router.sv
// rtl/torus_lookahead_router.sv - lookahead route computation for a 2D mesh/torus router input stage
module torus_lookahead_router
  import noc::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int X_DIM     = kXDim,
  parameter int Y_DIM     = kYDim,
  parameter int WRAP      = 1,
  parameter int X_FIRST   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  xy_t                             position,
  input  logic       [NUM_PORTS-1:0]      in_valid,
  output logic       [NUM_PORTS-1:0]      in_ready,
  input  logic       [NUM_PORTS-1:0]      in_head,
  input  logic       [NUM_PORTS-1:0]      in_tail,
  input  xy_t        [NUM_PORTS-1:0]      in_destination,
  input  direction_t [NUM_PORTS-1:0]      in_routing,
  output logic       [NUM_PORTS-1:0]      out_valid,
  input  logic       [NUM_PORTS-1:0]      out_ready,
  output direction_t [NUM_PORTS-1:0]      out_next_routing,
  output logic       [NUM_PORTS-1:0]      err
);

  xy_t r_position;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_position <= '0;
    else     r_position <= position;
  end

  // Step to the next router, then route from there toward the destination.
  function automatic route_res_t lookahead(input xy_t pos, input direction_t dir, input xy_t dst);
    route_res_t res;
    int         nx, ny, dx, dy;
    logic       off_edge, x_done, y_done;
    direction_t x_dir, y_dir;
    nx = int'(pos.x);
    ny = int'(pos.y);
    case (dir)
      goEast:  nx = nx + 1;
      goWest:  nx = nx - 1;
      goNorth: ny = ny - 1;
      goSouth: ny = ny + 1;
      default: ;
    endcase
    off_edge = (nx < 0) || (nx >= X_DIM) || (ny < 0) || (ny >= Y_DIM);
    if (WRAP != 0) begin
      nx       = (nx + X_DIM) % X_DIM;
      ny       = (ny + Y_DIM) % Y_DIM;
      off_edge = 1'b0;
      dx       = (int'(dst.x) - nx + X_DIM) % X_DIM;
      dy       = (int'(dst.y) - ny + Y_DIM) % Y_DIM;
      x_dir    = ((dx < X_DIM / 2) || ((dx == X_DIM / 2) && kTieEast)) ? goEast : goWest;
      y_dir    = ((dy < Y_DIM / 2) || ((dy == Y_DIM / 2) && kTieEast)) ? goSouth : goNorth;
    end else begin
      dx    = int'(dst.x) - nx;
      dy    = int'(dst.y) - ny;
      x_dir = (dx > 0) ? goEast : goWest;
      y_dir = (dy > 0) ? goSouth : goNorth;
    end
    x_done  = (dx == 0);
    y_done  = (dy == 0);
    res.dir = goLocal;
    res.err = 1'b0;
    if (dir == goLocal) begin
      res.dir = goLocal;
    end else if (!is_onehot(dir)) begin
      res.dir = dir;
      res.err = 1'b1;
    end else if (off_edge) begin
      res.err = 1'b1;
    end else if (X_FIRST != 0) begin
      if (!x_done)      res.dir = x_dir;
      else if (!y_done) res.dir = y_dir;
    end else begin
      if (!y_done)      res.dir = y_dir;
      else if (!x_done) res.dir = x_dir;
    end
    return res;
  endfunction

  route_res_t w_route [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign w_route[p] = lookahead(r_position, in_routing[p], in_destination[p]);

    lookahead_port_slice u_slice (
      .clk            (clk),
      .rst            (rst),
      .i_valid        (in_valid[p]),
      .o_ready        (in_ready[p]),
      .i_head         (in_head[p]),
      .i_tail         (in_tail[p]),
      .i_route        (w_route[p].dir),
      .i_route_err    (w_route[p].err),
      .o_valid        (out_valid[p]),
      .i_out_ready    (out_ready[p]),
      .o_next_routing (out_next_routing[p]),
      .o_err          (err[p])
    );
  end

endmodule

// File: tb/tb_torus_lookahead_router.sv
// tb/tb_torus_lookahead_router.sv - directed self-checking bench for torus_lookahead_router
module tb_torus_lookahead_router;
  import noc::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xy_t              t_pos, m_pos;
  logic [4:0]       t_valid, t_ready, t_head, t_tail, t_ovalid, t_oready, t_err;
  logic [4:0]       m_valid, m_ready, m_head, m_tail, m_ovalid, m_oready, m_err;
  xy_t [4:0]        t_dest, m_dest;
  direction_t [4:0] t_rt, t_nrt, m_rt, m_nrt;

  int n_pass = 0;
  int n_total = 0;

  torus_lookahead_router #(.NUM_PORTS(5), .X_DIM(4), .Y_DIM(4), .WRAP(1), .X_FIRST(1)) u_torus (
    .clk(clk), .rst(rst), .position(t_pos),
    .in_valid(t_valid), .in_ready(t_ready), .in_head(t_head), .in_tail(t_tail),
    .in_destination(t_dest), .in_routing(t_rt),
    .out_valid(t_ovalid), .out_ready(t_oready), .out_next_routing(t_nrt), .err(t_err)
  );

  torus_lookahead_router #(.NUM_PORTS(5), .X_DIM(4), .Y_DIM(4), .WRAP(0), .X_FIRST(1)) u_mesh (
    .clk(clk), .rst(rst), .position(m_pos),
    .in_valid(m_valid), .in_ready(m_ready), .in_head(m_head), .in_tail(m_tail),
    .in_destination(m_dest), .in_routing(m_rt),
    .out_valid(m_ovalid), .out_ready(m_oready), .out_next_routing(m_nrt), .err(m_err)
  );

  function automatic xy_t xy(input int x, input int y);
    xy_t r;
    r.x = x[kXW-1:0];
    r.y = y[kYW-1:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_total++; if (t_ovalid !== 5'b0) $display("FAIL reset_valid got %b want 00000", t_ovalid); else n_pass++;
    n_total++; if (t_nrt !== '0) $display("FAIL reset_route got %h want 0", t_nrt); else n_pass++;
    n_total++; if (t_err !== 5'b0) $display("FAIL reset_err got %b want 00000", t_err); else n_pass++;
    n_total++; if (t_ready !== 5'b11111) $display("FAIL reset_ready got %b want 11111", t_ready); else n_pass++;
    n_total++; if ((m_ovalid | m_err) !== 5'b0) $display("FAIL reset_mesh got %b/%b want 0/0", m_ovalid, m_err); else n_pass++;
    n_total++; if (m_ready !== 5'b11111) $display("FAIL reset_mesh_ready got %b want 11111", m_ready); else n_pass++;
  endtask

  task automatic test_torus_routes();
    t_valid = 5'b11101; t_head = 5'b11101; t_tail = 5'b11101;
    t_rt[0] = goWest;  t_dest[0] = xy(2, 0);
    t_rt[2] = goLocal; t_dest[2] = xy(3, 3);
    t_rt[3] = goEast;  t_dest[3] = xy(3, 2);
    t_rt[4] = goEast;  t_dest[4] = xy(1, 2);
    tick();
    t_valid = 5'b0;
    n_total++; if (t_ovalid !== 5'b11101) $display("FAIL torus_valid got %b want 11101", t_ovalid); else n_pass++;
    n_total++; if (t_nrt[0] !== goWest) $display("FAIL torus_wrap_west got %b want %b", t_nrt[0], goWest); else n_pass++;
    n_total++; if (t_nrt[2] !== goLocal) $display("FAIL torus_local got %b want %b", t_nrt[2], goLocal); else n_pass++;
    n_total++; if (t_nrt[3] !== goEast) $display("FAIL torus_tie_east got %b want %b", t_nrt[3], goEast); else n_pass++;
    n_total++; if (t_nrt[4] !== goSouth) $display("FAIL torus_tie_south got %b want %b", t_nrt[4], goSouth); else n_pass++;
    n_total++; if (t_err !== 5'b0) $display("FAIL torus_err got %b want 00000", t_err); else n_pass++;
    tick();
    n_total++; if (t_ovalid !== 5'b0) $display("FAIL torus_drain got %b want 00000", t_ovalid); else n_pass++;
  endtask

  task automatic test_mesh();
    m_valid = 5'b00010; m_head = 5'b00010; m_tail = 5'b00010;
    m_rt[1] = goWest; m_dest[1] = xy(0, 0);
    tick();
    m_valid = 5'b0;
    n_total++; if (m_ovalid[1] !== 1'b1) $display("FAIL mesh_edge_valid got %b want 1", m_ovalid[1]); else n_pass++;
    n_total++; if (m_nrt[1] !== goLocal) $display("FAIL mesh_edge_route got %b want %b", m_nrt[1], goLocal); else n_pass++;
    n_total++; if (m_err !== 5'b00010) $display("FAIL mesh_edge_err got %b want 00010", m_err); else n_pass++;
    m_pos = xy(1, 1);
    tick(); tick();
    m_valid = 5'b00101; m_head = 5'b00101; m_tail = 5'b00101;
    m_rt[0] = goNorth; m_dest[0] = xy(1, 0);
    m_rt[2] = goEast;  m_dest[2] = xy(0, 3);
    tick();
    m_valid = 5'b0;
    n_total++; if (m_nrt[0] !== goLocal) $display("FAIL mesh_arrive got %b want %b", m_nrt[0], goLocal); else n_pass++;
    n_total++; if (m_nrt[2] !== goWest) $display("FAIL mesh_no_wrap got %b want %b", m_nrt[2], goWest); else n_pass++;
    n_total++; if (m_err !== 5'b00010) $display("FAIL mesh_err_sticky got %b want 00010", m_err); else n_pass++;
  endtask

  task automatic test_packet_hold();
    t_valid = 5'b00010; t_head = 5'b00010; t_tail = 5'b0;
    t_rt[1] = goSouth; t_dest[1] = xy(3, 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      t_head = 5'b0; t_dest[1] = xy(0, 0);
      t_tail = (i == 2) ? 5'b00010 : 5'b0;
      n_total++;
      if (t_ovalid[1] !== 1'b1 || t_nrt[1] !== goWest)
        $display("FAIL pkt_hold_%0d got %b/%b want 1/%b", i, t_ovalid[1], t_nrt[1], goWest);
      else n_pass++;
    end
    n_total++; if (t_err !== 5'b0) $display("FAIL pkt_err got %b want 00000", t_err); else n_pass++;
    // Body flit after the tail: FSM must be back in IDLE.
    t_tail = 5'b0;
    tick();
    t_valid = 5'b0;
    n_total++; if (t_nrt[1] !== 5'b0) $display("FAIL idle_body_route got %b want 00000", t_nrt[1]); else n_pass++;
    n_total++; if (t_err !== 5'b00010) $display("FAIL idle_body_err got %b want 00010", t_err); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    t_oready[2] = 1'b0;
    t_valid = 5'b00100; t_head = 5'b00100; t_tail = 5'b00100;
    t_rt[2] = goEast; t_dest[2] = xy(3, 2);
    tick();
    t_rt[2] = goWest; t_dest[2] = xy(2, 0);
    n_total++; if (t_ovalid[2] !== 1'b1 || t_nrt[2] !== goEast)
      $display("FAIL bp_first got %b/%b want 1/%b", t_ovalid[2], t_nrt[2], goEast); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (t_ready[2] !== 1'b0) $display("FAIL bp_ready_%0d got %b want 0", i, t_ready[2]); else n_pass++;
      tick();
      n_total++; if (t_ovalid[2] !== 1'b1 || t_nrt[2] !== goEast)
        $display("FAIL bp_hold_%0d got %b/%b want 1/%b", i, t_ovalid[2], t_nrt[2], goEast); else n_pass++;
    end
    t_oready[2] = 1'b1;
    #1;
    n_total++; if (t_ready[2] !== 1'b1) $display("FAIL bp_release_ready got %b want 1", t_ready[2]); else n_pass++;
    tick();
    t_valid = 5'b0;
    n_total++; if (t_ovalid[2] !== 1'b1 || t_nrt[2] !== goWest)
      $display("FAIL bp_second got %b/%b want 1/%b", t_ovalid[2], t_nrt[2], goWest); else n_pass++;
    tick();
    n_total++; if (t_ovalid[2] !== 1'b0) $display("FAIL bp_no_dup got %b want 0", t_ovalid[2]); else n_pass++;
  endtask

  task automatic test_not_onehot();
    t_valid = 5'b11000; t_head = 5'b11000; t_tail = 5'b11000;
    t_rt[3] = 5'b00011; t_dest[3] = xy(1, 1);
    t_rt[4] = 5'b00000; t_dest[4] = xy(1, 1);
    tick();
    t_valid = 5'b0;
    n_total++; if (t_nrt[3] !== 5'b00011) $display("FAIL onehot_pass got %b want 00011", t_nrt[3]); else n_pass++;
    n_total++; if (t_nrt[4] !== 5'b00000) $display("FAIL zero_pass got %b want 00000", t_nrt[4]); else n_pass++;
    n_total++; if (t_err !== 5'b11010) $display("FAIL onehot_err got %b want 11010", t_err); else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    t_valid = 5'b00001; t_head = 5'b00001; t_tail = 5'b0;
    t_rt[0] = goEast; t_dest[0] = xy(3, 3);
    tick();
    t_valid = 5'b0;
    n_total++; if (t_ovalid[0] !== 1'b1 || t_nrt[0] !== goEast)
      $display("FAIL ar_head got %b/%b want 1/%b", t_ovalid[0], t_nrt[0], goEast); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (t_ovalid !== 5'b0) $display("FAIL ar_valid got %b want 00000", t_ovalid); else n_pass++;
    n_total++; if (t_err !== 5'b0) $display("FAIL ar_err got %b want 00000", t_err); else n_pass++;
    n_total++; if (m_err !== 5'b0) $display("FAIL ar_mesh_err got %b want 00000", m_err); else n_pass++;
    #2 rst = 1'b0;
    tick(); tick();
    t_valid = 5'b00001; t_head = 5'b0; t_tail = 5'b00001;
    tick();
    t_valid = 5'b0;
    n_total++; if (t_nrt[0] !== 5'b0 || t_err !== 5'b00001)
      $display("FAIL ar_idle got %b/%b want 00000/00001", t_nrt[0], t_err); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    t_pos = xy(0, 0); m_pos = xy(0, 1);
    t_valid = '0; t_head = '0; t_tail = '0; t_oready = '1; t_dest = '0; t_rt = '0;
    m_valid = '0; m_head = '0; m_tail = '0; m_oready = '1; m_dest = '0; m_rt = '0;
    tick(); tick();
    test_reset();
    rst = 1'b0;
    tick(); tick();
    test_torus_routes();
    test_mesh();
    test_packet_hold();
    test_back_to_back();
    test_not_onehot();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
